// File: rtl/regfile_pkg.sv
// regfile_pkg: shared register-file constants, forward-select encodings and scoreboard entry type.
package regfile_pkg;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 8;

    localparam logic [1:0] FWD_NONE = 2'b00;
    localparam logic [1:0] FWD_EX   = 2'b01;
    localparam logic [1:0] FWD_MEM  = 2'b10;
    localparam logic [1:0] FWD_WB   = 2'b11;

    typedef struct packed {
        logic              valid;
        logic [ADDR_W-1:0] rd;
        logic              writes;
        logic              is_load;
    } sb_entry_t;

    // Youngest producer wins.
    function automatic logic [1:0] fwd_sel(input logic ex_hit, input logic mem_hit, input logic wb_hit);
        return ex_hit ? FWD_EX : mem_hit ? FWD_MEM : wb_hit ? FWD_WB : FWD_NONE;
    endfunction
endpackage

// File: rtl/sb_stage_reg.sv
// sb_stage_reg: one scoreboard pipeline entry with load-or-bubble capture and per-source matching.
module sb_stage_reg
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  sb_entry_t         i_entry,
    input  logic [ADDR_W-1:0] i_rs,
    input  logic [ADDR_W-1:0] i_rt,
    output sb_entry_t         o_entry,
    output logic              o_match_rs,
    output logic              o_match_rt
);
    sb_entry_t r_entry;
    logic      w_live;

    always_ff @(posedge clk or posedge rst)
        if (rst) r_entry <= '0;
        else     r_entry <= i_load ? i_entry : '0;

    assign w_live     = r_entry.valid & r_entry.writes;
    assign o_entry    = r_entry;
    assign o_match_rs = w_live & (r_entry.rd == i_rs) & (i_rs != '0);
    assign o_match_rt = w_live & (r_entry.rd == i_rt) & (i_rt != '0);
endmodule

// File: rtl/reg_scoreboard.sv
// reg_scoreboard: EX/MEM/WB destination tracking, forwarding selects, load-use stall and WB write control.
// Optional stall counter enabled by defining SCOREBOARD_STATS_EN.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = regfile_pkg::ADDR_W,
    parameter int NUM_REGS = regfile_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_rs,
    input  logic [ADDR_W-1:0] issue_rt,
    input  logic [ADDR_W-1:0] issue_rd,
    input  logic              issue_writes,
    input  logic              issue_is_load,
    input  logic              flush,
    output logic              stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              wb_reg_write,
    output logic [ADDR_W-1:0] wb_write_reg
`ifdef SCOREBOARD_STATS_EN
    ,
    output logic [15:0]       stall_count
`endif
);
    localparam int RD_W = $clog2(NUM_REGS);

    sb_entry_t w_issue, w_ex, w_mem, w_wb;
    logic      w_ex_rs, w_ex_rt, w_mem_rs, w_mem_rt, w_wb_rs, w_wb_rt;
    logic      w_stall, w_accept, w_wb_live, w_fwd_en, w_unused;

    // r0 is never a real destination, so it enters the pipe as a non-writer.
    assign w_issue = '{valid: 1'b1, rd: issue_rd[RD_W-1:0], writes: issue_writes & (issue_rd != '0), is_load: issue_is_load};

    assign w_stall  = issue_valid & ~flush & w_ex.is_load & (w_ex_rs | w_ex_rt);
    assign w_accept = issue_valid & ~w_stall & ~flush;

    sb_stage_reg u_ex (
        .clk(clk), .rst(rst), .i_load(w_accept), .i_entry(w_issue),
        .i_rs(issue_rs), .i_rt(issue_rt), .o_entry(w_ex), .o_match_rs(w_ex_rs), .o_match_rt(w_ex_rt)
    );
    sb_stage_reg u_mem (
        .clk(clk), .rst(rst), .i_load(~flush), .i_entry(w_ex),
        .i_rs(issue_rs), .i_rt(issue_rt), .o_entry(w_mem), .o_match_rs(w_mem_rs), .o_match_rt(w_mem_rt)
    );
    sb_stage_reg u_wb (
        .clk(clk), .rst(rst), .i_load(1'b1), .i_entry(w_mem),
        .i_rs(issue_rs), .i_rt(issue_rt), .o_entry(w_wb), .o_match_rs(w_wb_rs), .o_match_rt(w_wb_rt)
    );

    // A load still in EX has no result yet, so it never feeds the EX bypass.
    assign w_fwd_en = issue_valid & ~w_stall;
    assign fwd_a    = w_fwd_en ? fwd_sel(w_ex_rs & ~w_ex.is_load, w_mem_rs, w_wb_rs) : FWD_NONE;
    assign fwd_b    = w_fwd_en ? fwd_sel(w_ex_rt & ~w_ex.is_load, w_mem_rt, w_wb_rt) : FWD_NONE;
    assign stall    = w_stall;

    assign w_wb_live    = w_wb.valid & w_wb.writes;
    assign wb_reg_write = w_wb_live;
    assign wb_write_reg = w_wb_live ? w_wb.rd : '0;
    assign w_unused     = w_wb.is_load;

`ifdef SCOREBOARD_STATS_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or posedge rst)
        if (rst)                                   r_stall_count <= '0;
        else if (w_stall && r_stall_count != '1)   r_stall_count <= r_stall_count + 16'd1;

    assign stall_count = r_stall_count;
`endif
endmodule

// File: tb/tb_reg_scoreboard.sv
// tb_reg_scoreboard: directed scenarios plus randomized issue streams against an issue-history model.
module tb_reg_scoreboard;
    logic       clk, rst;
    logic       issue_valid, issue_writes, issue_is_load, flush;
    logic [2:0] issue_rs, issue_rt, issue_rd;
    logic       stall, wb_reg_write;
    logic [1:0] fwd_a, fwd_b;
    logic [2:0] wb_write_reg;
`ifdef SCOREBOARD_STATS_EN
    logic [15:0] stall_count;
`endif

    int n_chk = 0;
    int n_pass = 0;

    bit         acc [0:511];
    bit         mwr [0:511];
    bit         mld [0:511];
    logic [2:0] mrd [0:511];

    reg_scoreboard dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .issue_rs(issue_rs), .issue_rt(issue_rt),
        .issue_rd(issue_rd), .issue_writes(issue_writes), .issue_is_load(issue_is_load), .flush(flush),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .wb_reg_write(wb_reg_write), .wb_write_reg(wb_write_reg)
`ifdef SCOREBOARD_STATS_EN
        , .stall_count(stall_count)
`endif
    );

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] rs, input logic [2:0] rt, input logic [2:0] rd,
                         input logic w, input logic ld, input logic fl);
        issue_valid = v; issue_rs = rs; issue_rt = rt; issue_rd = rd;
        issue_writes = w; issue_is_load = ld; flush = fl;
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        tick();
        rst = 0;
    endtask

    // Expected forward select for source s at a point t edges after reset, from the issue history.
    function automatic logic [1:0] model_fwd(input int t, input logic [2:0] s);
        for (int k = 0; k < 3; k++) begin
            int e = t - k;
            if (e >= 1 && acc[e] && mwr[e] && mrd[e] == s && s != 0 && !(k == 0 && mld[e]))
                return 2'(k + 1);
        end
        return 2'b00;
    endfunction

    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0);
        rst = 1;
        #2;
        n_chk++; if ({stall, fwd_a, fwd_b, wb_reg_write, wb_write_reg} !== '0)
            $display("FAIL reset_outputs: got %b want 0", {stall, fwd_a, fwd_b, wb_reg_write, wb_write_reg}); else n_pass++;
`ifdef SCOREBOARD_STATS_EN
        n_chk++; if (stall_count !== 16'd0) $display("FAIL reset_stall_count: got %0d want 0", stall_count); else n_pass++;
`endif
        tick();
        rst = 0;
    endtask

    task automatic test_alu_fwd();
        do_reset();
        drive(1, 0, 0, 3, 1, 0, 0);
        tick();
        drive(1, 3, 0, 0, 0, 0, 0);
        #1;
        n_chk++; if (fwd_a !== 2'b01) $display("FAIL alu_fwd_a: got %b want 01", fwd_a); else n_pass++;
        n_chk++; if (stall !== 1'b0) $display("FAIL alu_stall: got %b want 0", stall); else n_pass++;
    endtask

    task automatic test_load_use();
        do_reset();
        drive(1, 0, 0, 5, 1, 1, 0);
        tick();
        drive(1, 0, 5, 0, 0, 0, 0);
        #1;
        n_chk++; if (stall !== 1'b1) $display("FAIL lu_stall: got %b want 1", stall); else n_pass++;
        n_chk++; if (fwd_b !== 2'b00) $display("FAIL lu_fwd_b_stalled: got %b want 00", fwd_b); else n_pass++;
        tick();
        n_chk++; if (stall !== 1'b0) $display("FAIL lu_stall_after: got %b want 0", stall); else n_pass++;
        n_chk++; if (fwd_b !== 2'b10) $display("FAIL lu_fwd_b_mem: got %b want 10", fwd_b); else n_pass++;
        n_chk++; if (wb_reg_write !== 1'b0) $display("FAIL lu_wb_early: got %b want 0", wb_reg_write); else n_pass++;
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        #1;
        n_chk++; if (wb_reg_write !== 1'b1 || wb_write_reg !== 3'd5)
            $display("FAIL lu_wb: got %b/%0d want 1/5", wb_reg_write, wb_write_reg); else n_pass++;
        tick();
        n_chk++; if (wb_reg_write !== 1'b0) $display("FAIL lu_wb_once: got %b want 0", wb_reg_write); else n_pass++;
    endtask

    task automatic test_priority();
        do_reset();
        drive(1, 0, 0, 2, 1, 0, 0);
        tick(); tick(); tick();
        drive(1, 2, 0, 0, 0, 0, 0);
        #1;
        n_chk++; if (fwd_a !== 2'b01) $display("FAIL prio_ex: got %b want 01", fwd_a); else n_pass++;
        n_chk++; if (fwd_b !== 2'b00) $display("FAIL prio_b_r0: got %b want 00", fwd_b); else n_pass++;
        drive(0, 2, 0, 0, 0, 0, 0);
        #1;
        n_chk++; if (fwd_a !== 2'b00) $display("FAIL prio_invalid: got %b want 00", fwd_a); else n_pass++;
        drive(1, 2, 0, 0, 0, 0, 0);
        tick();
        n_chk++; if (fwd_a !== 2'b10) $display("FAIL prio_mem: got %b want 10", fwd_a); else n_pass++;
        tick();
        n_chk++; if (fwd_a !== 2'b11) $display("FAIL prio_wb: got %b want 11", fwd_a); else n_pass++;
        n_chk++; if (wb_reg_write !== 1'b1 || wb_write_reg !== 3'd2)
            $display("FAIL prio_wb_write: got %b/%0d want 1/2", wb_reg_write, wb_write_reg); else n_pass++;
        tick();
        n_chk++; if (fwd_a !== 2'b00 || wb_reg_write !== 1'b0)
            $display("FAIL prio_drained: got %b/%b want 00/0", fwd_a, wb_reg_write); else n_pass++;
    endtask

    task automatic test_r0();
        do_reset();
        drive(1, 0, 0, 0, 1, 0, 0);
        tick();
        drive(1, 0, 0, 0, 0, 0, 0);
        #1;
        n_chk++; if (fwd_a !== 2'b00) $display("FAIL r0_fwd_a: got %b want 00", fwd_a); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        n_chk++; if (wb_reg_write !== 1'b0 || wb_write_reg !== 3'd0)
            $display("FAIL r0_wb: got %b/%0d want 0/0", wb_reg_write, wb_write_reg); else n_pass++;
    endtask

    task automatic test_flush();
        do_reset();
        drive(1, 0, 0, 4, 1, 1, 0);
        tick();
        drive(1, 4, 0, 0, 0, 0, 1);
        #1;
        n_chk++; if (stall !== 1'b0) $display("FAIL flush_stall: got %b want 0", stall); else n_pass++;
        tick();
        drive(1, 4, 4, 0, 0, 0, 0);
        #1;
        n_chk++; if (fwd_a !== 2'b00 || fwd_b !== 2'b00 || stall !== 1'b0)
            $display("FAIL flush_empty: got %b/%b/%b want 00/00/0", fwd_a, fwd_b, stall); else n_pass++;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (wb_reg_write !== 1'b0) $display("FAIL flush_no_write%0d: got %b want 0", i, wb_reg_write); else n_pass++;
            tick();
        end
    endtask

    task automatic test_random();
        int n_stall = 0;
        do_reset();
        for (int i = 0; i < 512; i++) acc[i] = 0;
        for (int t = 0; t < 400; t++) begin
            logic       v, w, ld, fl, exp_stall, exp_wr;
            logic [2:0] rs, rt, rd, exp_reg;
            logic [1:0] exp_a, exp_b;
            int         wb_e;
            v  = ($urandom % 4) != 0;
            rs = 3'($urandom_range(0, 3));
            rt = 3'($urandom_range(0, 3));
            rd = 3'($urandom_range(0, 3));
            w  = ($urandom % 4) != 0;
            ld = ($urandom % 3) == 0;
            fl = ($urandom % 10) == 0;
            drive(v, rs, rt, rd, w, ld, fl);
            exp_stall = v && !fl && t >= 1 && acc[t] && mwr[t] && mld[t] &&
                        ((mrd[t] == rs && rs != 0) || (mrd[t] == rt && rt != 0));
            exp_a = (v && !exp_stall) ? model_fwd(t, rs) : 2'b00;
            exp_b = (v && !exp_stall) ? model_fwd(t, rt) : 2'b00;
            wb_e = t - 2;
            exp_wr = wb_e >= 1 && acc[wb_e] && mwr[wb_e];
            exp_reg = exp_wr ? mrd[wb_e] : 3'd0;
            #1;
            n_chk++; if (stall !== exp_stall) $display("FAIL rnd_stall t=%0d: got %b want %b", t, stall, exp_stall); else n_pass++;
            n_chk++; if (fwd_a !== exp_a) $display("FAIL rnd_fwd_a t=%0d: got %b want %b", t, fwd_a, exp_a); else n_pass++;
            n_chk++; if (fwd_b !== exp_b) $display("FAIL rnd_fwd_b t=%0d: got %b want %b", t, fwd_b, exp_b); else n_pass++;
            n_chk++; if (wb_reg_write !== exp_wr || wb_write_reg !== exp_reg)
                $display("FAIL rnd_wb t=%0d: got %b/%0d want %b/%0d", t, wb_reg_write, wb_write_reg, exp_wr, exp_reg); else n_pass++;
            if (exp_stall) n_stall++;
            tick();
            if (fl) acc[t] = 0;
            acc[t+1] = v && !exp_stall && !fl;
            mrd[t+1] = rd;
            mwr[t+1] = w && rd != 0;
            mld[t+1] = ld;
        end
`ifdef SCOREBOARD_STATS_EN
        n_chk++; if (stall_count !== 16'(n_stall)) $display("FAIL rnd_stall_count: got %0d want %0d", stall_count, n_stall); else n_pass++;
`else
        if (n_stall == 0) $display("note: random run produced no stalls");
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        drive(1, 0, 0, 6, 1, 0, 0);
        tick(); tick(); tick();
        drive(1, 6, 6, 0, 0, 0, 0);
        #1;
        n_chk++; if (fwd_a !== 2'b01 || wb_reg_write !== 1'b1)
            $display("FAIL mid_pre: got %b/%b want 01/1", fwd_a, wb_reg_write); else n_pass++;
        rst = 1;
        #1;
        n_chk++; if ({stall, fwd_a, fwd_b, wb_reg_write, wb_write_reg} !== '0)
            $display("FAIL mid_reset_outputs: got %b want 0", {stall, fwd_a, fwd_b, wb_reg_write, wb_write_reg}); else n_pass++;
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++; if (wb_reg_write !== 1'b0) $display("FAIL mid_no_write%0d: got %b want 0", i, wb_reg_write); else n_pass++;
        end
    endtask

`ifdef SCOREBOARD_STATS_EN
    task automatic test_stats();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(1, 0, 0, 1, 1, 1, 0);
            tick();
            drive(1, 1, 0, 0, 0, 0, 0);
            tick();
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        n_chk++; if (stall_count !== 16'd3) $display("FAIL stats_count: got %0d want 3", stall_count); else n_pass++;
        rst = 1;
        #1;
        n_chk++; if (stall_count !== 16'd0) $display("FAIL stats_reset: got %0d want 0", stall_count); else n_pass++;
        rst = 0;
    endtask
`endif

    initial begin
        rst = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_priority();
        test_r0();
        test_flush();
        test_random();
        test_reset_mid();
`ifdef SCOREBOARD_STATS_EN
        test_stats();
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
